// File: rtl/atm_session_ctrl_if.sv
// Bus between the keypad/card-reader front end, the account store and the
// ATM session controller. The front end drives the master side and the
// controller sits on the slave side.
interface atm_session_ctrl_if #(
    parameter int PIN_W = 14,
    parameter int AMT_W = 32
);
    logic             card_in;
    logic             enter;
    logic [PIN_W-1:0] code;
    logic [PIN_W-1:0] exp_pin;
    logic [AMT_W-1:0] amount;
    logic [AMT_W-1:0] balance_in;

    logic [3:0]       msg;
    logic [2:0]       tries_left;
    logic             cash_valid;
    logic [AMT_W-1:0] cash_amt;
    logic             balance_wr;
    logic [AMT_W-1:0] balance_out;
    logic             eject_card;
    logic             retain_card;

    modport master (
        output card_in, enter, code, exp_pin, amount, balance_in,
        input  msg, tries_left, cash_valid, cash_amt, balance_wr,
               balance_out, eject_card, retain_card
    );

    modport slave (
        input  card_in, enter, code, exp_pin, amount, balance_in,
        output msg, tries_left, cash_valid, cash_amt, balance_wr,
               balance_out, eject_card, retain_card
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insertion, PIN entry with retry limit and
// card retention, a menu loop for withdrawals and balance queries, an
// inactivity timeout and a balance write-back strobe.
// Optional per-session withdrawal cap: define ATM_SESSION_LIMIT_EN.
module atm_session_ctrl #(
    parameter int PIN_W         = 14,
    parameter int AMT_W         = 32,
    parameter int MAX_TRIES     = 3,
    parameter int TIMEOUT_CYC   = 1024,
    parameter int SESSION_LIMIT = 1000
) (
    input logic               clk,
    input logic               rst,
    atm_session_ctrl_if.slave bus
);
    // Counter only has to reach TIMEOUT_CYC-1; expiry moves to EXIT
    localparam int                CNT_W      = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]        TRIES_INIT = 3'(MAX_TRIES);

    // Encodings equal the display codes, so msg is the state register itself
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK_PIN = 4'd1,
        S_INVALID   = 4'd2,
        S_MENU      = 4'd3,
        S_AMOUNT    = 4'd4,
        S_QUERY     = 4'd5,
        S_NO_FUNDS  = 4'd6,
        S_DISPENSE  = 4'd7,
        S_EXIT      = 4'd8,
        S_RETAIN    = 4'd9
    } state_t;

    state_t           state_q, state_n;
    logic [2:0]       tries_q, tries_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             cash_valid_q, cash_valid_n;
    logic [AMT_W-1:0] cash_amt_q, cash_amt_n;
    logic             bal_wr_q, bal_wr_n;
    logic [AMT_W-1:0] bal_out_q, bal_out_n;
    logic             eject_q, retain_q;
    logic             timed;
    logic             expired;
    logic             limit_hit;

`ifdef ATM_SESSION_LIMIT_EN
    localparam int SUM_W = AMT_W + 2;

    logic [AMT_W:0]   sess_acc_q;
    logic [SUM_W-1:0] sess_sum;

    // Would this request push the session total past the cap
    always_comb begin
        sess_sum  = {1'b0, sess_acc_q} + {2'b00, bus.amount};
        limit_hit = (sess_sum > SUM_W'(SESSION_LIMIT));
    end

    // Session total: cleared between cards, grows by each dispensed amount
    always_ff @(posedge clk) begin
        if (rst) begin
            sess_acc_q <= '0;
        end else if (state_q == S_IDLE) begin
            sess_acc_q <= '0;
        end else if (state_q == S_DISPENSE) begin
            sess_acc_q <= sess_acc_q + {1'b0, cash_amt_q};
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    // Inactivity timer runs only in states that wait for the customer
    always_comb begin
        timed   = (state_q == S_CHECK_PIN) || (state_q == S_MENU) ||
                  (state_q == S_AMOUNT)    || (state_q == S_QUERY);
        expired = timed && !bus.enter && (cnt_q == CNT_LAST);
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_n      = state_q;
        tries_n      = tries_q;
        cash_valid_n = 1'b0;
        cash_amt_n   = cash_amt_q;
        bal_wr_n     = 1'b0;
        bal_out_n    = bal_out_q;
        cnt_n        = '0;

        if (!bus.card_in && state_q != S_RETAIN) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_CHECK_PIN;
                    tries_n = TRIES_INIT;
                end
                S_CHECK_PIN: begin
                    if (bus.enter) begin
                        if (bus.code == bus.exp_pin) begin
                            state_n = S_MENU;
                        end else begin
                            tries_n = tries_q - 3'd1;
                            if (tries_q == 3'd1) begin
                                state_n = S_RETAIN;
                            end
                        end
                    end else if (expired) begin
                        state_n = S_EXIT;
                    end
                end
                S_MENU: begin
                    if (bus.enter) begin
                        if (bus.code == PIN_W'(1)) begin
                            state_n = S_AMOUNT;
                        end else if (bus.code == PIN_W'(2)) begin
                            state_n   = S_QUERY;
                            bal_out_n = bus.balance_in;
                        end else if (bus.code == PIN_W'(3)) begin
                            state_n = S_EXIT;
                        end else begin
                            state_n = S_INVALID;
                        end
                    end else if (expired) begin
                        state_n = S_EXIT;
                    end
                end
                S_AMOUNT: begin
                    if (bus.enter) begin
                        if (bus.amount == '0) begin
                            state_n = S_INVALID;
                        end else if (limit_hit) begin
                            state_n = S_NO_FUNDS;
                        end else if (bus.amount > bus.balance_in) begin
                            state_n = S_NO_FUNDS;
                        end else begin
                            state_n      = S_DISPENSE;
                            cash_valid_n = 1'b1;
                            cash_amt_n   = bus.amount;
                            bal_wr_n     = 1'b1;
                            bal_out_n    = bus.balance_in - bus.amount;
                        end
                    end else if (expired) begin
                        state_n = S_EXIT;
                    end
                end
                S_QUERY: begin
                    bal_out_n = bus.balance_in;
                    if (bus.enter) begin
                        state_n = S_MENU;
                    end else if (expired) begin
                        state_n = S_EXIT;
                    end
                end
                S_INVALID, S_NO_FUNDS, S_DISPENSE: begin
                    state_n = S_MENU;
                end
                S_EXIT: begin
                    state_n = S_EXIT;
                end
                S_RETAIN: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        if (timed && !bus.enter && state_n == state_q) begin
            cnt_n = cnt_q + 1'b1;
        end
    end

    // State, timer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tries_q      <= TRIES_INIT;
            cnt_q        <= '0;
            cash_valid_q <= 1'b0;
            cash_amt_q   <= '0;
            bal_wr_q     <= 1'b0;
            bal_out_q    <= '0;
            eject_q      <= 1'b0;
            retain_q     <= 1'b0;
        end else begin
            state_q      <= state_n;
            tries_q      <= tries_n;
            cnt_q        <= cnt_n;
            cash_valid_q <= cash_valid_n;
            cash_amt_q   <= cash_amt_n;
            bal_wr_q     <= bal_wr_n;
            bal_out_q    <= bal_out_n;
            eject_q      <= (state_n == S_EXIT);
            retain_q     <= (state_n == S_RETAIN);
        end
    end

    assign bus.msg         = state_q;
    assign bus.tries_left  = tries_q;
    assign bus.cash_valid  = cash_valid_q;
    assign bus.cash_amt    = cash_amt_q;
    assign bus.balance_wr  = bal_wr_q;
    assign bus.balance_out = bal_out_q;
    assign bus.eject_card  = eject_q;
    assign bus.retain_card = retain_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: a session-level reference model checked against
// the DUT every cycle, plus directed sessions with hand-computed expectations.
module tb_atm_session_ctrl;
    localparam int PIN_W         = 14;
    localparam int AMT_W         = 32;
    localparam int MAX_TRIES     = 3;
    localparam int TIMEOUT_CYC   = 16;
    localparam int SESSION_LIMIT = 300;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   misses  = 0;
    bit   done    = 1'b0;

    atm_session_ctrl_if #(.PIN_W(PIN_W), .AMT_W(AMT_W)) bus();

    atm_session_ctrl #(
        .PIN_W(PIN_W), .AMT_W(AMT_W), .MAX_TRIES(MAX_TRIES),
        .TIMEOUT_CYC(TIMEOUT_CYC), .SESSION_LIMIT(SESSION_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Reference model: screen shown, attempts left, strobes and held values
    int               mScreen;
    int               mTries;
    int               mQuiet;
    logic             mCashValid;
    logic [AMT_W-1:0] mCashAmt;
    logic             mBalWr;
    logic [AMT_W-1:0] mBalOut;
`ifdef ATM_SESSION_LIMIT_EN
    longint           mSessTotal;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // One clock of customer-visible behaviour, driven by the screen being shown
    task automatic modelStep();
        int     nxt;
        bit     en;
        longint amt;
        longint bal;
        en  = bus.enter;
        amt = longint'(bus.amount);
        bal = longint'(bus.balance_in);
        mCashValid = 1'b0;
        mBalWr     = 1'b0;
        if (rst) begin
            mScreen  = 0;
            mTries   = MAX_TRIES;
            mCashAmt = '0;
            mBalOut  = '0;
            mQuiet   = 0;
`ifdef ATM_SESSION_LIMIT_EN
            mSessTotal = 0;
`endif
        end else begin
            nxt = mScreen;
`ifdef ATM_SESSION_LIMIT_EN
            if (mScreen == 0) mSessTotal = 0;
            if (mScreen == 7) mSessTotal += longint'(mCashAmt);
`endif
            if (!bus.card_in && mScreen != 9) begin
                nxt = 0;
            end else if (mScreen == 0) begin
                nxt    = 1;
                mTries = MAX_TRIES;
            end else if (mScreen == 1) begin
                if (en && bus.code == bus.exp_pin) nxt = 3;
                else if (en) begin
                    mTries--;
                    if (mTries == 0) nxt = 9;
                end
            end else if (mScreen == 3) begin
                if (en) begin
                    if (bus.code == 1) nxt = 4;
                    else if (bus.code == 2) begin nxt = 5; mBalOut = bus.balance_in; end
                    else if (bus.code == 3) nxt = 8;
                    else nxt = 2;
                end
            end else if (mScreen == 4) begin
                if (en) begin
                    if (amt == 0) nxt = 2;
`ifdef ATM_SESSION_LIMIT_EN
                    else if (mSessTotal + amt > SESSION_LIMIT) nxt = 6;
`endif
                    else if (amt > bal) nxt = 6;
                    else begin
                        nxt        = 7;
                        mCashValid = 1'b1;
                        mCashAmt   = bus.amount;
                        mBalWr     = 1'b1;
                        mBalOut    = AMT_W'(bal - amt);
                    end
                end
            end else if (mScreen == 5) begin
                mBalOut = bus.balance_in;
                if (en) nxt = 3;
            end else if (mScreen == 2 || mScreen == 6 || mScreen == 7) begin
                nxt = 3;
            end else if (mScreen == 9) begin
                nxt = 0;
            end
            // Waiting screens count quiet cycles; a full window forces EXIT
            if ((mScreen == 1 || mScreen == 3 || mScreen == 4 || mScreen == 5) && !en && nxt == mScreen) begin
                mQuiet++;
                if (mQuiet >= TIMEOUT_CYC) nxt = 8;
            end
            if (en || nxt != mScreen) mQuiet = 0;
            mScreen = nxt;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Compare every output against the model just after each edge
    initial forever begin
        @(posedge clk);
        #1;
        if (!done) begin
            checkOutput("msg", bus.msg, mScreen);
            checkOutput("tries_left", bus.tries_left, mTries);
            checkOutput("cash_valid", bus.cash_valid, mCashValid);
            if (mCashValid) checkOutput("cash_amt", bus.cash_amt, mCashAmt);
            checkOutput("balance_wr", bus.balance_wr, mBalWr);
            checkOutput("balance_out", bus.balance_out, mBalOut);
            checkOutput("eject_card", bus.eject_card, mScreen == 8);
            checkOutput("retain_card", bus.retain_card, mScreen == 9);
        end
    end

    // Drive one cycle of inputs; returns after the edge that consumed them
    task automatic applyStimulus(input logic card, input logic en, input int c, input int amt);
        bus.card_in = card;
        bus.enter   = en;
        bus.code    = PIN_W'(c);
        bus.amount  = AMT_W'(amt);
        @(negedge clk);
        bus.enter   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        bus.card_in    = 1'b0;
        bus.enter      = 1'b0;
        bus.code       = '0;
        bus.amount     = '0;
        bus.exp_pin    = PIN_W'(1234);
        bus.balance_in = AMT_W'(500);
        repeat (2) @(negedge clk);
        checkOutput("reset_msg", bus.msg, 0);
        checkOutput("reset_tries", bus.tries_left, 3);
        checkOutput("reset_eject", bus.eject_card, 0);
        checkOutput("reset_cash_amt", bus.cash_amt, 0);
        rst = 1'b0;

        // PIN retries then success
        applyStimulus(1, 0, 0, 0);
        checkOutput("pin_screen", bus.msg, 1);
        applyStimulus(1, 1, 1111, 0);
        checkOutput("pin_tries2", bus.tries_left, 2);
        applyStimulus(1, 1, 2222, 0);
        checkOutput("pin_tries1", bus.tries_left, 1);
        applyStimulus(1, 1, 1234, 0);
        checkOutput("pin_menu", bus.msg, 3);

        // Withdraw 200 of 500
        applyStimulus(1, 1, 1, 0);
        checkOutput("amount_screen", bus.msg, 4);
        applyStimulus(1, 1, 0, 200);
        checkOutput("disp_msg", bus.msg, 7);
        checkOutput("disp_valid", bus.cash_valid, 1);
        checkOutput("disp_amt", bus.cash_amt, 200);
        checkOutput("disp_bal", bus.balance_out, 300);
        idleCycles(1);
        checkOutput("disp_back", bus.msg, 3);
        checkOutput("disp_valid_off", bus.cash_valid, 0);

        // Over-balance request
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 600);
        checkOutput("nofunds_msg", bus.msg, 6);
        idleCycles(1);
        checkOutput("nofunds_back", bus.msg, 3);

        // Query, invalid code, zero amount
        applyStimulus(1, 1, 2, 0);
        checkOutput("query_bal", bus.balance_out, 500);
        idleCycles(1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("query_back", bus.msg, 3);
        applyStimulus(1, 1, 7, 0);
        checkOutput("invalid_msg", bus.msg, 2);
        idleCycles(1);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("zero_amt", bus.msg, 2);
        idleCycles(1);

        // Timeout in MENU, then hold in EXIT until the card leaves
        idleCycles(TIMEOUT_CYC - 1);
        checkOutput("timeout_not_yet", bus.msg, 3);
        idleCycles(1);
        checkOutput("timeout_exit", bus.msg, 8);
        checkOutput("timeout_eject", bus.eject_card, 1);
        idleCycles(3);
        applyStimulus(0, 0, 0, 0);
        checkOutput("exit_idle", bus.msg, 0);

        // Enter on the expiry cycle wins over the timeout
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1234, 0);
        idleCycles(TIMEOUT_CYC - 1);
        applyStimulus(1, 1, 2, 0);
        checkOutput("expiry_enter", bus.msg, 5);
        applyStimulus(1, 1, 0, 0);

        // Card pulled in AMOUNT while pressing enter
        applyStimulus(1, 1, 1, 0);
        applyStimulus(0, 1, 0, 200);
        checkOutput("pull_idle", bus.msg, 0);
        checkOutput("pull_no_cash", bus.cash_valid, 0);

        // Three wrong PINs retain the card for one cycle
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 2, 0);
        applyStimulus(1, 1, 3, 0);
        checkOutput("retain_msg", bus.msg, 9);
        checkOutput("retain_flag", bus.retain_card, 1);
        checkOutput("retain_tries", bus.tries_left, 0);
        idleCycles(1);
        checkOutput("retain_idle", bus.msg, 0);
        checkOutput("retain_off", bus.retain_card, 0);
        idleCycles(1);
        checkOutput("reinsert_tries", bus.tries_left, 3);
        applyStimulus(0, 0, 0, 0);

        // Reset while dispensing
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1234, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 100);
        checkOutput("pre_reset_disp", bus.msg, 7);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_msg", bus.msg, 0);
        checkOutput("rst_cash", bus.cash_valid, 0);
        checkOutput("rst_wr", bus.balance_wr, 0);
        checkOutput("rst_eject", bus.eject_card, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);

`ifdef ATM_SESSION_LIMIT_EN
        // Session cap of 300 against a balance of 1000
        bus.balance_in = AMT_W'(1000);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1234, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 200);
        checkOutput("limit_first", bus.msg, 7);
        idleCycles(1);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 150);
        checkOutput("limit_block", bus.msg, 6);
        idleCycles(1);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 100);
        checkOutput("limit_last", bus.msg, 7);
        checkOutput("limit_amt", bus.cash_amt, 100);
        checkOutput("limit_bal", bus.balance_out, 900);
        applyStimulus(0, 0, 0, 0);
`endif

        idleCycles(2);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
